pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

- Sequences the RISC-V pipeline registers (16-bit enable/clear flip-flop stages) from hazard and status inputs.
- Generates per-stage enable and synchronous-clear controls for PC, IF/ID, ID/EX and EX/MEM, covering:
  - load-use stalls;
  - branch-redirect flushes, including fetch-latency bubbles;
  - whole-pipe freezes during multi-cycle memory accesses.
- Also keeps saturating stall/flush performance counters and a sticky memory-timeout error.
- Sits beside the decode/hazard unit; its outputs drive the stage registers directly.

## Interface
Parameters:
- EXTRA_FLUSH, 1: bubble cycles after the redirect cycle that cover synchronous instruction-memory latency. Range 0..3.
- MEM_TIMEOUT, 16'd1000: number of consecutive mem_busy cycles in MEMWAIT that sets err. Range 1..65535.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_busy  in  1  data memory has not completed; freeze the whole pipe.
- branch_taken  in  1  EX resolved a taken branch or jump this cycle.
- load_use  in  1  decode detected a dependency on a load in EX.
- pc_en  out  1  PC register load enable.
- ifid_en  out  1  IF/ID hold when 0.
- ifid_clr  out  1  IF/ID synchronous clear (bubble); has priority over ifid_en.
- idex_en  out  1  ID/EX hold when 0.
- idex_clr  out  1  ID/EX synchronous clear; has priority over idex_en.
- exmem_en  out  1  EX/MEM hold when 0.
- stall_cnt  out  16  number of cycles with pc_en=0; saturates at 16'hFFFF.
- flush_cnt  out  16  number of accepted branch redirects; saturates at 16'hFFFF.
- err  out  1  sticky memory timeout; cleared only by rst.

## Operation
- **Output timing:** control outputs are combinational (Mealy) from the current state and inputs, so they act on the same edge. Counters, err and state are registered.
- **Input priority:** mem_busy > branch_taken > load_use.
- **States:** RUN, FLUSH, MEMWAIT. Internal registers:
  - fcnt (2-bit): remaining flush bubbles;
  - wdog (16-bit): watchdog count.
- **Reset:**
  - state=RUN, fcnt=0, wdog=0, stall_cnt=0, flush_cnt=0, err=0.
  - While rst=1, outputs are pc_en=ifid_en=idex_en=exmem_en=1 and ifid_clr=idex_clr=1, which flushes all stage contents.
- **RUN:**
  - mem_busy: all enables 0, no clears; wdog<=1; next state MEMWAIT.
  - Otherwise branch_taken:
    - enables all 1, ifid_clr=1, idex_clr=1; flush_cnt++.
    - If EXTRA_FLUSH>0: fcnt<=EXTRA_FLUSH and next state FLUSH. Otherwise stay in RUN.
  - Otherwise load_use: pc_en=0, ifid_en=0, idex_clr=1, exmem_en=1; stay in RUN. This is a single bubble; the controller does not track load_use beyond the current cycle.
  - Otherwise all enables 1, no clears.
- **FLUSH:**
  - mem_busy: freeze exactly as in RUN; fcnt is retained; next state MEMWAIT.
  - Otherwise branch_taken: same outputs as a RUN redirect; fcnt reloads to EXTRA_FLUSH; flush_cnt++; stay in FLUSH.
  - Otherwise:
    - enables all 1, ifid_clr=1; load_use is ignored (ID holds a bubble).
    - fcnt--. When fcnt reaches 0, next state RUN.
- **MEMWAIT:**
  - mem_busy=1: all enables 0, no clears.
    - wdog increments and saturates.
    - When wdog==MEM_TIMEOUT, err<=1. The state stays MEMWAIT.
  - mem_busy=0 (release cycle): decoded exactly as RUN for branch_taken/load_use. If nothing applies:
    - fcnt!=0: next state FLUSH, with FLUSH outputs in that cycle;
    - fcnt==0: next state RUN.
  - wdog<=0 on exit.
- **Counters:**
  - stall_cnt increments in every non-reset cycle where pc_en=0.
  - No counter wraps.

## Timing
- Zero-cycle control latency: a hazard input asserted before edge N affects the register loads at edge N.
- Load-use costs exactly 1 bubble.
- A taken branch costs 1+EXTRA_FLUSH bubbles, plus any MEMWAIT cycles.
- err rises on the edge after the MEM_TIMEOUT-th consecutive busy cycle in MEMWAIT.
- Reset asserted mid-MEMWAIT or mid-FLUSH aborts the operation: the next state is RUN and all counters are 0.

## Structure
- Shared package `pipe_ctrl_pkg` holds:
  - the state enum (RUN, FLUSH, MEMWAIT);
  - the 16-bit saturation max constant;
  - default EXTRA_FLUSH and MEM_TIMEOUT.
- One sub-module, `sat_counter16`: 16-bit saturating counter with synchronous clear and increment enable. It is instantiated for stall_cnt and flush_cnt, and reused for wdog.

## Test plan
- **Reset:** pulse rst 2 cycles with random inputs.
  - During rst: both clears are 1.
  - After release with idle inputs: all enables 1, clears 0, counters 0, err=0.
- **Load-use:** load_use=1 for 1 cycle.
  - That cycle: pc_en=0, ifid_en=0, idex_clr=1.
  - Next cycle: all enables 1.
  - stall_cnt=1.
- **Branch, EXTRA_FLUSH=1:** branch_taken for 1 cycle.
  - Cycle 0: ifid_clr=idex_clr=1.
  - Cycle 1: ifid_clr=1 only.
  - Cycle 2: RUN.
  - flush_cnt=1.
- **Branch in FLUSH:** a second branch_taken during FLUSH reloads fcnt, giving 2 further bubble cycles in total; flush_cnt=2.
- **Memory freeze across a flush:** mem_busy for 5 cycles starting in the FLUSH bubble.
  - Enables are 0 for 5 cycles; stall_cnt=5.
  - On release, the FLUSH bubble resumes, then RUN.
  - Also assert mem_busy together with branch_taken: the freeze wins and flush_cnt does not change.
- **Timeout:** MEM_TIMEOUT=8 with mem_busy for 10 cycles.
  - err goes to 1 after the 8th busy cycle in MEMWAIT.
  - err stays 1 after release and clears only on rst.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e          : controller states (RUN, FLUSH, MEMWAIT)
//   SAT_MAX          : value at which all 16-bit counters stop
//   DEF_EXTRA_FLUSH  : default bubble cycles after a redirect (0..3)
//   DEF_MEM_TIMEOUT  : default consecutive busy cycles that raise err
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_e;

    localparam logic [15:0] SAT_MAX         = 16'hFFFF;
    localparam int unsigned DEF_EXTRA_FLUSH = 1;
    localparam logic [15:0] DEF_MEM_TIMEOUT = 16'd1000;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating up-counter.
//   clk    : rising-edge clock
//   clr_i  : synchronous clear, has priority over inc_i
//   inc_i  : increment enable; the count holds at SAT_MAX
//   cnt_o  : current count
module sat_counter16
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr_i,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != SAT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: turns hazard/status inputs into per-stage
// enable and synchronous-clear controls for PC, IF/ID, ID/EX and EX/MEM.
//   clk, rst      : clock, synchronous active-high reset
//   mem_busy      : data memory not done -> freeze the whole pipe
//   branch_taken  : EX resolved a taken branch/jump this cycle
//   load_use      : decode depends on a load currently in EX
//   pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en : stage controls
//                   (Mealy, act on the same edge; clr beats en)
//   stall_cnt     : saturating count of cycles with pc_en=0
//   flush_cnt     : saturating count of accepted redirects
//   err           : sticky memory timeout, cleared only by rst
//   state_dbg     : current controller state, for observation
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned EXTRA_FLUSH = DEF_EXTRA_FLUSH,
    parameter logic [15:0] MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_busy,
    input  logic        branch_taken,
    input  logic        load_use,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_clr,
    output logic        idex_en,
    output logic        idex_clr,
    output logic        exmem_en,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        err,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] FLUSH_LOAD = 2'(EXTRA_FLUSH);

    state_e      state_q, state_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic        err_q;
    logic        err_set;
    logic        redirect;
    logic [15:0] wdog;
    logic        wdog_clr;

    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        ifid_clr = 1'b0;
        idex_en  = 1'b1;
        idex_clr = 1'b0;
        exmem_en = 1'b1;
        redirect = 1'b0;
        err_set  = 1'b0;

        if (rst) begin
            // Load every stage with a bubble while reset is held.
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
            state_d  = ST_RUN;
            fcnt_d   = 2'd0;
        end else if (mem_busy) begin
            // Freeze; fcnt is kept so an interrupted flush resumes later.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            state_d  = ST_MEMWAIT;
            if ((state_q == ST_MEMWAIT) && (wdog == MEM_TIMEOUT)) begin
                err_set = 1'b1;
            end
        end else if (branch_taken) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
            redirect = 1'b1;
            fcnt_d   = FLUSH_LOAD;
            state_d  = (EXTRA_FLUSH != 0) ? ST_FLUSH : ST_RUN;
        end else if ((state_q == ST_FLUSH) ||
                     ((state_q == ST_MEMWAIT) && (fcnt_q != 2'd0) && !load_use)) begin
            // Fetch-latency bubble. A MEMWAIT release with bubbles pending
            // is itself the resumed bubble, so it also consumes one.
            ifid_clr = 1'b1;
            fcnt_d   = fcnt_q - 2'd1;
            state_d  = (fcnt_d == 2'd0) ? ST_RUN : ST_FLUSH;
        end else if (load_use) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
            fcnt_d   = 2'd0;
            state_d  = ST_RUN;
        end else begin
            state_d  = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= 2'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // wdog is always 0 outside MEMWAIT, so counting the entry busy cycle
    // from RUN/FLUSH yields the required load of 1.
    assign wdog_clr = rst || ((state_q == ST_MEMWAIT) && !mem_busy);

    sat_counter16 u_stall_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (!rst && !pc_en),
        .cnt_o (stall_cnt)
    );

    sat_counter16 u_flush_cnt (
        .clk   (clk),
        .clr_i (rst),
        .inc_i (redirect),
        .cnt_o (flush_cnt)
    );

    sat_counter16 u_wdog (
        .clk   (clk),
        .clr_i (wdog_clr),
        .inc_i (!rst && mem_busy),
        .cnt_o (wdog)
    );

    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int EF = 1;
  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        mem_busy;
  logic        branch_taken;
  logic        load_use;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_clr;
  logic        idex_en;
  logic        idex_clr;
  logic        exmem_en;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        err;
  logic [1:0]  state_dbg;

  pipe_hazard_ctrl #(
    .EXTRA_FLUSH (EF),
    .MEM_TIMEOUT (16'(TO))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_busy     (mem_busy),
    .branch_taken (branch_taken),
    .load_use     (load_use),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_clr     (ifid_clr),
    .idex_en      (idex_en),
    .idex_clr     (idex_clr),
    .exmem_en     (exmem_en),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .err          (err),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard: {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en,
  //              stall_cnt, flush_cnt, err}
  logic [38:0] exp_q[$];
  logic [38:0] msk_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model: bubbles still owed, whether the pipe is frozen,
  // how many busy cycles have elapsed since the freeze began
  int m_bub     = 0;
  bit m_frozen  = 0;
  int m_wcnt    = 0;
  int m_stalls  = 0;
  int m_flushes = 0;
  bit m_err     = 0;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic step(input bit r, input bit m, input bit b, input bit l);
    logic [5:0]  ctl;
    logic [5:0]  cmask;
    logic [32:0] regs;
    bit          was_frozen;
    @(posedge clk);
    #2;
    rst          = r;
    mem_busy     = m;
    branch_taken = b;
    load_use     = l;
    regs  = {m_stalls[15:0], m_flushes[15:0], m_err};
    cmask = 6'b111111;
    if (r) begin
      ctl       = 6'b111111;
      m_bub     = 0;
      m_frozen  = 0;
      m_wcnt    = 0;
      m_stalls  = 0;
      m_flushes = 0;
      m_err     = 0;
    end else if (m) begin
      ctl      = 6'b000000;
      m_stalls = sat(m_stalls + 1);
      if (m_frozen) begin
        m_wcnt = m_wcnt + 1;
        if (m_wcnt == TO) m_err = 1;
      end else begin
        m_frozen = 1;
        m_wcnt   = 0;
      end
    end else begin
      was_frozen = m_frozen;
      m_frozen   = 0;
      if (b) begin
        ctl       = 6'b111111;
        m_flushes = sat(m_flushes + 1);
        m_bub     = EF;
      end else if (m_bub > 0 && !(was_frozen && l)) begin
        ctl   = 6'b111101;
        m_bub = m_bub - 1;
      end else if (l) begin
        // ID/EX is cleared, so its enable does not matter
        ctl      = 6'b000111;
        cmask    = 6'b111011;
        m_stalls = sat(m_stalls + 1);
        m_bub    = 0;
      end else begin
        ctl = 6'b110101;
      end
    end
    exp_q.push_back({ctl, regs});
    msk_q.push_back({cmask, 33'h1_FFFF_FFFF});
  endtask

  // monitor
  initial begin
    logic [38:0] e;
    logic [38:0] mk;
    logic [38:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        mk  = msk_q.pop_front();
        act = {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en,
               stall_cnt, flush_cnt, err};
        total++;
        if ((act & mk) !== (e & mk)) begin
          bad++;
          $display("FAIL cycle%0d outputs act=%h exp=%h", cyc, act, e);
        end
        cyc++;
      end
    end
  end

  // driver
  initial begin
    int burst;
    bit r, m, b, l;
    rst = 1'b1; mem_busy = 1'b0; branch_taken = 1'b0; load_use = 1'b0;

    // reset with random inputs
    repeat (2) step(1, 1'($urandom), 1'($urandom), 1'($urandom));
    repeat (2) step(0, 0, 0, 0);
    // load-use
    step(0, 0, 0, 1);
    repeat (2) step(0, 0, 0, 0);
    // branch
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    // branch during flush
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    // freeze across a flush bubble
    step(0, 0, 1, 0);
    repeat (5) step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // freeze beats branch
    step(0, 1, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    // timeout, sticky until reset
    repeat (10) step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);

    // random traffic
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      if (burst == 0 && $urandom_range(0, 19) == 0) burst = $urandom_range(1, 12);
      m = (burst > 0);
      if (burst > 0) burst--;
      b = ($urandom_range(0, 7) == 0);
      l = ($urandom_range(0, 5) == 0);
      step(r, m, b, l);
    end

    repeat (4) begin
      if (exp_q.size() > 0) @(negedge clk);
    end
    #1;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
